// File: rtl/riscv_inst_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : riscv_inst_decode_stage
// Description : RV32 decode stage with registered output and a skid register.
//               Optional flush port enabled by RISCV_DECODE_FLUSH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_inst_decode_stage (
    input  logic        clk,
    input  logic        resetn,
`ifdef RISCV_DECODE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst_data,
    input  logic [31:0] inst_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [2:0]  dec_class,
    output logic [4:0]  dec_rd,
    output logic [4:0]  dec_rs1,
    output logic [4:0]  dec_rs2,
    output logic [2:0]  dec_funct3,
    output logic [6:0]  dec_funct7,
    output logic [31:0] dec_imm,
    output logic        dec_illegal
);

    localparam logic [2:0] c_CLS_R       = 3'd0;
    localparam logic [2:0] c_CLS_I       = 3'd1;
    localparam logic [2:0] c_CLS_S       = 3'd2;
    localparam logic [2:0] c_CLS_B       = 3'd3;
    localparam logic [2:0] c_CLS_U       = 3'd4;
    localparam logic [2:0] c_CLS_J       = 3'd5;
    localparam logic [2:0] c_CLS_CUSTOM0 = 3'd6;
    localparam logic [2:0] c_CLS_ILLEGAL = 3'd7;

    localparam logic [6:0] c_OP_R       = 7'b0110011;
    localparam logic [6:0] c_OP_I       = 7'b0010011;
    localparam logic [6:0] c_OP_S       = 7'b0100011;
    localparam logic [6:0] c_OP_B       = 7'b1100011;
    localparam logic [6:0] c_OP_U       = 7'b0010111;
    localparam logic [6:0] c_OP_J       = 7'b1101111;
    localparam logic [6:0] c_OP_CUSTOM0 = 7'b0001011;

    localparam logic [6:0] c_F7_ZERO = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    logic        w_flush;
    logic        w_accept;
    logic        w_drain;
    logic        w_out_free;
    logic        w_out_valid_nxt;
    logic        w_skid_valid_nxt;
    logic        w_ld_out_from_skid;
    logic        w_ld_out_from_in;
    logic        w_ld_skid_from_in;
    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [2:0]  w_cls;
    logic [31:0] w_imm;
    dec_t        w_dec;

    logic        r_out_valid;
    logic        r_skid_valid;
    logic        r_inst_ready;
    dec_t        r_out;
    dec_t        r_skid;

`ifdef RISCV_DECODE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_opcode = inst_data[6:0];
    assign w_f3     = inst_data[14:12];
    assign w_f7     = inst_data[31:25];

    always_comb begin
        w_cls = c_CLS_ILLEGAL;
        case (w_opcode)
            c_OP_R: begin
                if (w_f7 == c_F7_ZERO)
                    w_cls = c_CLS_R;
                else if (w_f7 == c_F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101))
                    w_cls = c_CLS_R;
            end
            c_OP_I: begin
                // Only the shift encodings constrain funct7.
                if (w_f3 == 3'b001)
                    w_cls = (w_f7 == c_F7_ZERO) ? c_CLS_I : c_CLS_ILLEGAL;
                else if (w_f3 == 3'b101)
                    w_cls = (w_f7 == c_F7_ZERO || w_f7 == c_F7_ALT) ? c_CLS_I : c_CLS_ILLEGAL;
                else
                    w_cls = c_CLS_I;
            end
            c_OP_S:       w_cls = (w_f3 <= 3'b010) ? c_CLS_S : c_CLS_ILLEGAL;
            c_OP_B:       w_cls = (w_f3 == 3'b010 || w_f3 == 3'b011) ? c_CLS_ILLEGAL : c_CLS_B;
            c_OP_U:       w_cls = c_CLS_U;
            c_OP_J:       w_cls = c_CLS_J;
            c_OP_CUSTOM0: w_cls = (w_f3 == 3'b000) ? c_CLS_CUSTOM0 : c_CLS_ILLEGAL;
            default:      w_cls = c_CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        w_imm = 32'd0;
        case (w_cls)
            c_CLS_I: w_imm = {{20{inst_data[31]}}, inst_data[31:20]};
            c_CLS_S: w_imm = {{20{inst_data[31]}}, inst_data[31:25], inst_data[11:7]};
            c_CLS_B: w_imm = {{19{inst_data[31]}}, inst_data[31], inst_data[7],
                              inst_data[30:25], inst_data[11:8], 1'b0};
            c_CLS_U: w_imm = {inst_data[31:12], 12'd0};
            c_CLS_J: w_imm = {{11{inst_data[31]}}, inst_data[31], inst_data[19:12],
                              inst_data[20], inst_data[30:21], 1'b0};
            default: w_imm = 32'd0;
        endcase
    end

    always_comb begin
        w_dec.pc      = inst_pc;
        w_dec.cls     = w_cls;
        w_dec.rd      = inst_data[11:7];
        w_dec.rs1     = inst_data[19:15];
        w_dec.rs2     = inst_data[24:20];
        w_dec.funct3  = w_f3;
        w_dec.funct7  = w_f7;
        w_dec.imm     = w_imm;
        w_dec.illegal = (w_cls == c_CLS_ILLEGAL);
    end

    assign w_accept   = inst_valid && r_inst_ready && !w_flush;
    assign w_drain    = r_out_valid && dec_ready;
    assign w_out_free = !r_out_valid || w_drain;

    always_comb begin
        w_out_valid_nxt    = r_out_valid;
        w_skid_valid_nxt   = r_skid_valid;
        w_ld_out_from_skid = 1'b0;
        w_ld_out_from_in   = 1'b0;
        w_ld_skid_from_in  = 1'b0;
        if (w_flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_out_free) begin
            // A held skid entry is always older than the incoming word.
            if (r_skid_valid) begin
                w_ld_out_from_skid = 1'b1;
                w_out_valid_nxt    = 1'b1;
                w_skid_valid_nxt   = w_accept;
                w_ld_skid_from_in  = w_accept;
            end else if (w_accept) begin
                w_ld_out_from_in = 1'b1;
                w_out_valid_nxt  = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_ld_skid_from_in = 1'b1;
            w_skid_valid_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_inst_ready <= 1'b1;
            r_out        <= '0;
            r_skid       <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_inst_ready <= !w_skid_valid_nxt;
            if (w_ld_out_from_skid)
                r_out <= r_skid;
            else if (w_ld_out_from_in)
                r_out <= w_dec;
            if (w_ld_skid_from_in)
                r_skid <= w_dec;
        end
    end

    assign inst_ready  = r_inst_ready;
    assign dec_valid   = r_out_valid;
    assign dec_pc      = r_out.pc;
    assign dec_class   = r_out.cls;
    assign dec_rd      = r_out.rd;
    assign dec_rs1     = r_out.rs1;
    assign dec_rs2     = r_out.rs2;
    assign dec_funct3  = r_out.funct3;
    assign dec_funct7  = r_out.funct7;
    assign dec_imm     = r_out.imm;
    assign dec_illegal = r_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_riscv_inst_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_inst_decode_stage
// Description : Directed self-checking bench for riscv_inst_decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_inst_decode_stage;

    logic        clk;
    logic        resetn;
`ifdef RISCV_DECODE_FLUSH_EN
    logic        flush;
`endif
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [2:0]  dec_class;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm;
    logic        dec_illegal;

    int pass_cnt;
    int total_cnt;

    riscv_inst_decode_stage dut (
        .clk         (clk),
        .resetn      (resetn),
`ifdef RISCV_DECODE_FLUSH_EN
        .flush       (flush),
`endif
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_class   (dec_class),
        .dec_rd      (dec_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_funct3  (dec_funct3),
        .dec_funct7  (dec_funct7),
        .dec_imm     (dec_imm),
        .dec_illegal (dec_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; results are read on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] data, input logic [31:0] pc);
        inst_valid = 1'b1;
        inst_data  = data;
        inst_pc    = pc;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (dec_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", dec_valid); else pass_cnt++;
        total_cnt++;
        if (inst_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", inst_ready); else pass_cnt++;
        total_cnt++;
        if (dec_pc !== 32'd0 || dec_imm !== 32'd0)
            $display("FAIL reset_data got pc %h imm %h want 0", dec_pc, dec_imm);
        else pass_cnt++;
        total_cnt++;
        if (dec_class !== 3'd0 || dec_illegal !== 1'b0 || dec_rd !== 5'd0 || dec_funct7 !== 7'd0)
            $display("FAIL reset_fields got class %0d ill %0b rd %0d f7 %h want 0",
                     dec_class, dec_illegal, dec_rd, dec_funct7);
        else pass_cnt++;
        resetn = 1'b1;
    endtask

    task automatic test_addi();
        dec_ready = 1'b1;
        offer(32'hFFF10093, 32'h0000_0040);
        step();
        inst_valid = 1'b0;
        total_cnt++;
        if (dec_valid !== 1'b1 || dec_class !== 3'd1 || dec_rd !== 5'd1 || dec_rs1 !== 5'd2)
            $display("FAIL addi_fields got v %0b class %0d rd %0d rs1 %0d want 1 1 1 2",
                     dec_valid, dec_class, dec_rd, dec_rs1);
        else pass_cnt++;
        total_cnt++;
        if (dec_imm !== 32'hFFFFFFFF || dec_illegal !== 1'b0 || dec_pc !== 32'h40)
            $display("FAIL addi_imm got imm %h ill %0b pc %h want ffffffff 0 40",
                     dec_imm, dec_illegal, dec_pc);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dec_valid !== 1'b0) $display("FAIL addi_drained got %0b want 0", dec_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        dec_ready = 1'b1;
        offer(32'h00532423, 32'h0000_0010);
        step();
        offer(32'hFFDFF0EF, 32'h0000_0014);
        total_cnt++;
        if (dec_class !== 3'd2 || dec_rs1 !== 5'd6 || dec_rs2 !== 5'd5 || dec_imm !== 32'h8 || dec_pc !== 32'h10)
            $display("FAIL sw got class %0d rs1 %0d rs2 %0d imm %h pc %h want 2 6 5 8 10",
                     dec_class, dec_rs1, dec_rs2, dec_imm, dec_pc);
        else pass_cnt++;
        step();
        inst_valid = 1'b0;
        total_cnt++;
        if (dec_valid !== 1'b1 || dec_class !== 3'd5 || dec_rd !== 5'd1 || dec_imm !== 32'hFFFFFFFC || dec_pc !== 32'h14)
            $display("FAIL jal got v %0b class %0d rd %0d imm %h pc %h want 1 5 1 fffffffc 14",
                     dec_valid, dec_class, dec_rd, dec_imm, dec_pc);
        else pass_cnt++;
        step();
    endtask

    task automatic test_classes();
        logic [31:0] vec_inst [12];
        logic [2:0]  vec_cls  [12];
        logic [31:0] vec_imm  [12];
        vec_inst[0]  = 32'h00000000; vec_cls[0]  = 3'd7; vec_imm[0]  = 32'h0;
        vec_inst[1]  = 32'h40001033; vec_cls[1]  = 3'd7; vec_imm[1]  = 32'h0;
        vec_inst[2]  = 32'h40000033; vec_cls[2]  = 3'd0; vec_imm[2]  = 32'h0;
        vec_inst[3]  = 32'h40005013; vec_cls[3]  = 3'd1; vec_imm[3]  = 32'h00000400;
        vec_inst[4]  = 32'h40001013; vec_cls[4]  = 3'd7; vec_imm[4]  = 32'h0;
        vec_inst[5]  = 32'hFE112E23; vec_cls[5]  = 3'd2; vec_imm[5]  = 32'hFFFFFFFC;
        vec_inst[6]  = 32'h00003023; vec_cls[6]  = 3'd7; vec_imm[6]  = 32'h0;
        vec_inst[7]  = 32'hFE000EE3; vec_cls[7]  = 3'd3; vec_imm[7]  = 32'hFFFFFFFC;
        vec_inst[8]  = 32'h00002063; vec_cls[8]  = 3'd7; vec_imm[8]  = 32'h0;
        vec_inst[9]  = 32'h12345017; vec_cls[9]  = 3'd4; vec_imm[9]  = 32'h12345000;
        vec_inst[10] = 32'h0000000B; vec_cls[10] = 3'd6; vec_imm[10] = 32'h0;
        vec_inst[11] = 32'h0000100B; vec_cls[11] = 3'd7; vec_imm[11] = 32'h0;
        dec_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            offer(vec_inst[i], 32'h200 + 32'(i * 4));
            step();
            total_cnt++;
            if (dec_valid !== 1'b1 || dec_class !== vec_cls[i] || dec_imm !== vec_imm[i] ||
                dec_illegal !== (vec_cls[i] == 3'd7) || dec_pc !== 32'h200 + 32'(i * 4))
                $display("FAIL class_vec%0d inst %h got v %0b class %0d imm %h ill %0b pc %h want class %0d imm %h",
                         i, vec_inst[i], dec_valid, dec_class, dec_imm, dec_illegal, dec_pc,
                         vec_cls[i], vec_imm[i]);
            else pass_cnt++;
        end
        inst_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        dec_ready = 1'b0;
        offer(32'h00100093, 32'h100);
        step();
        total_cnt++;
        if (inst_ready !== 1'b1) $display("FAIL bp_ready1 got %0b want 1", inst_ready); else pass_cnt++;
        offer(32'h00200093, 32'h104);
        step();
        total_cnt++;
        if (inst_ready !== 1'b0 || dec_pc !== 32'h100)
            $display("FAIL bp_full got ready %0b pc %h want 0 100", inst_ready, dec_pc);
        else pass_cnt++;
        offer(32'h00300093, 32'h108);
        step();
        total_cnt++;
        if (inst_ready !== 1'b0 || dec_valid !== 1'b1 || dec_pc !== 32'h100 || dec_imm !== 32'h1)
            $display("FAIL bp_hold got ready %0b v %0b pc %h imm %h want 0 1 100 1",
                     inst_ready, dec_valid, dec_pc, dec_imm);
        else pass_cnt++;
        dec_ready = 1'b1;
        step();
        total_cnt++;
        if (dec_pc !== 32'h104 || dec_imm !== 32'h2 || inst_ready !== 1'b1)
            $display("FAIL bp_second got pc %h imm %h ready %0b want 104 2 1", dec_pc, dec_imm, inst_ready);
        else pass_cnt++;
        step();
        inst_valid = 1'b0;
        total_cnt++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h108 || dec_imm !== 32'h3)
            $display("FAIL bp_third got v %0b pc %h imm %h want 1 108 3", dec_valid, dec_pc, dec_imm);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dec_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", dec_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        dec_ready = 1'b0;
        offer(32'h00100093, 32'h180);
        step();
        offer(32'h00200093, 32'h184);
        step();
        inst_valid = 1'b0;
        #1 resetn = 1'b0;
        #1;
        total_cnt++;
        if (dec_valid !== 1'b0 || inst_ready !== 1'b1)
            $display("FAIL rstmid_ctrl got v %0b ready %0b want 0 1", dec_valid, inst_ready);
        else pass_cnt++;
        total_cnt++;
        if (dec_pc !== 32'd0 || dec_imm !== 32'd0 || dec_class !== 3'd0 || dec_rs1 !== 5'd0 || dec_funct3 !== 3'd0)
            $display("FAIL rstmid_data got pc %h imm %h class %0d want 0 0 0", dec_pc, dec_imm, dec_class);
        else pass_cnt++;
        #1 resetn = 1'b1;
        dec_ready = 1'b1;
        offer(32'h00000013, 32'h1C0);
        step();
        inst_valid = 1'b0;
        total_cnt++;
        if (dec_valid !== 1'b1 || dec_class !== 3'd1 || dec_imm !== 32'd0 || dec_pc !== 32'h1C0)
            $display("FAIL rstmid_nop got v %0b class %0d imm %h pc %h want 1 1 0 1c0",
                     dec_valid, dec_class, dec_imm, dec_pc);
        else pass_cnt++;
        step();
        total_cnt++;
        if (dec_valid !== 1'b0) $display("FAIL rstmid_empty got %0b want 0", dec_valid); else pass_cnt++;
    endtask

`ifdef RISCV_DECODE_FLUSH_EN
    task automatic test_flush();
        dec_ready = 1'b0;
        offer(32'h00100093, 32'h300);
        step();
        offer(32'h00200093, 32'h304);
        step();
        flush = 1'b1;
        offer(32'h00500093, 32'h308);
        step();
        flush      = 1'b0;
        inst_valid = 1'b0;
        total_cnt++;
        if (dec_valid !== 1'b0 || inst_ready !== 1'b1)
            $display("FAIL flush_ctrl got v %0b ready %0b want 0 1", dec_valid, inst_ready);
        else pass_cnt++;
        dec_ready = 1'b1;
        step();
        step();
        total_cnt++;
        if (dec_valid !== 1'b0) $display("FAIL flush_drop got v %0b pc %h want 0", dec_valid, dec_pc); else pass_cnt++;
    endtask
`endif

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        resetn     = 1'b0;
        inst_valid = 1'b0;
        inst_data  = 32'd0;
        inst_pc    = 32'd0;
        dec_ready  = 1'b0;
`ifdef RISCV_DECODE_FLUSH_EN
        flush      = 1'b0;
`endif
        test_reset();
        test_addi();
        test_back_to_back();
        test_classes();
        test_backpressure();
        test_reset_mid();
`ifdef RISCV_DECODE_FLUSH_EN
        test_flush();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
